// File: rtl/adder_result_buffer.sv
// rtl/adder_result_buffer.sv - show-ahead result FIFO behind the pipelined adder
// Captures {carry, sum} results, back-pressures the adder, keeps result statistics.
module adder_result_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_sum,
   input  logic                   in_carry,
   output logic                   in_allow,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_sum,
   output logic                   out_carry,
   output logic [$clog2(DEPTH):0] count,
   output logic [15:0]            accepted_cnt,
   output logic [15:0]            carry_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH:0]  mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     accepted_q, accepted_d;
   logic [15:0]     carry_q, carry_d;
   logic            push;
   logic            pop;

   // in_allow depends only on registered occupancy: no ready-to-allow path when full
   assign in_allow     = (count_q != FULL);
   assign out_valid    = (count_q != '0);
   assign {out_carry, out_sum} = mem_q[rd_ptr_q];
   assign count        = count_q;
   assign accepted_cnt = accepted_q;
   assign carry_cnt    = carry_q;

   assign push = in_valid && in_allow && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      accepted_d = accepted_q;
      carry_d    = carry_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            accepted_d = accepted_q + 16'd1;
            if (in_carry && carry_q != 16'hFFFF) begin
               carry_d = carry_q + 16'd1;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         accepted_q <= '0;
         carry_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         accepted_q <= accepted_d;
         carry_q    <= carry_d;
      end
   end

   // Storage is never cleared; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_carry, in_sum};
      end
   end

endmodule

// File: tb/tb_adder_result_buffer.sv
// tb/tb_adder_result_buffer.sv - self-checking bench for adder_result_buffer
// Scoreboard queue of expected results plus a reference occupancy/statistics model.
module tb_adder_result_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_sum = '0;
   logic             in_carry = 1'b0;
   logic             in_allow;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic [CW-1:0]    count;
   logic [15:0]      accepted_cnt;
   logic [15:0]      carry_cnt;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   logic [WIDTH:0] exp_q[$];
   int             m_acc = 0;
   int             m_car = 0;

   adder_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry), .in_allow(in_allow),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
      .count(count), .accepted_cnt(accepted_cnt), .carry_cnt(carry_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: compare against the model mid-cycle, then advance the model for the coming edge
   always @(negedge clk) begin
      int sz;
      bit do_push;
      bit do_pop;
      sz = exp_q.size();
      if (mon_en) begin
         checks++;
         if (count !== CW'(sz)) begin
            errors++; $display("FAIL mon_count: got %0d expected %0d", count, sz);
         end
         checks++;
         if (in_allow !== (sz != DEPTH)) begin
            errors++; $display("FAIL mon_in_allow: got %b expected %b", in_allow, sz != DEPTH);
         end
         checks++;
         if (out_valid !== (sz != 0)) begin
            errors++; $display("FAIL mon_out_valid: got %b expected %b", out_valid, sz != 0);
         end
         checks++;
         if (accepted_cnt !== 16'(m_acc)) begin
            errors++; $display("FAIL mon_accepted: got %0d expected %0d", accepted_cnt, m_acc);
         end
         checks++;
         if (carry_cnt !== 16'(m_car)) begin
            errors++; $display("FAIL mon_carry_cnt: got %0d expected %0d", carry_cnt, m_car);
         end
         if (sz != 0 && out_ready && !rst && !flush) begin
            checks++;
            if ({out_carry, out_sum} !== exp_q[0]) begin
               errors++;
               $display("FAIL mon_pop_data: got carry=%b sum=%h expected carry=%b sum=%h",
                        out_carry, out_sum, exp_q[0][WIDTH], exp_q[0][WIDTH-1:0]);
            end
         end
      end
      if (rst) begin
         exp_q.delete();
         m_acc = 0;
         m_car = 0;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         do_push = in_valid && (sz != DEPTH);
         do_pop  = (sz != 0) && out_ready;
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) begin
            exp_q.push_back({in_carry, in_sum});
            m_acc = (m_acc + 1) % 65536;
            if (in_carry && m_car != 65535) m_car++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_carry = 1'b0; in_sum = '0;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_allow !== 1'b1 || out_valid !== 1'b0 || count !== '0 ||
          accepted_cnt !== 16'd0 || carry_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got allow=%b valid=%b count=%0d acc=%0d car=%0d expected 1 0 0 0 0",
                  in_allow, out_valid, count, accepted_cnt, carry_cnt);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_single_push();
      do_reset();
      in_valid = 1'b1; in_sum = 32'h0000_0003; in_carry = 1'b0;
      cyc(1);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h3 || count !== CW'(1) || accepted_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_push: got valid=%b sum=%h count=%0d acc=%0d expected 1 00000003 1 1",
                  out_valid, out_sum, count, accepted_cnt);
      end
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_sum = 32'h10 + 32'(i);
         cyc(1);
      end
      in_sum = 32'h14;
      cyc(2);
      checks++;
      if (in_allow !== 1'b0 || count !== CW'(4)) begin
         errors++; $display("FAIL full_state: got allow=%b count=%0d expected 0 4", in_allow, count);
      end
      out_ready = 1'b1;
      cyc(1);
      checks++;
      if (in_allow !== 1'b1 || count !== CW'(3)) begin
         errors++; $display("FAIL full_after_pop: got allow=%b count=%0d expected 1 3", in_allow, count);
      end
      cyc(1);
      in_valid = 1'b0;
      cyc(3);
      out_ready = 1'b0;
      checks++;
      if (count !== '0 || accepted_cnt !== 16'd5) begin
         errors++; $display("FAIL full_drain: got count=%0d acc=%0d expected 0 5", count, accepted_cnt);
      end
   endtask

   task automatic test_streaming_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         in_valid = 1'b1; in_sum = 32'(i);
         cyc(1);
         checks++;
         if (count !== CW'(1) || out_sum !== 32'(i)) begin
            errors++; $display("FAIL stream_%0d: got count=%0d sum=%0d expected 1 %0d", i, count, out_sum, i);
         end
      end
      in_valid = 1'b0;
      cyc(1);
      out_ready = 1'b0;
      checks++;
      if (count !== '0 || accepted_cnt !== 16'd12) begin
         errors++; $display("FAIL stream_end: got count=%0d acc=%0d expected 0 12", count, accepted_cnt);
      end
   endtask

   task automatic test_carry_stats();
      logic [WIDTH:0] pat [5];
      pat[0] = {1'b1, 32'h0}; pat[1] = {1'b0, 32'h5}; pat[2] = {1'b1, 32'h0};
      pat[3] = {1'b0, 32'h6}; pat[4] = {1'b1, 32'h0};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; {in_carry, in_sum} = pat[i];
         cyc(1);
         checks++;
         if (out_carry !== pat[i][WIDTH]) begin
            errors++; $display("FAIL carry_out_%0d: got %b expected %b", i, out_carry, pat[i][WIDTH]);
         end
      end
      in_valid = 1'b0; in_carry = 1'b0;
      cyc(1);
      out_ready = 1'b0;
      checks++;
      if (carry_cnt !== 16'd3 || accepted_cnt !== 16'd5) begin
         errors++; $display("FAIL carry_stats: got car=%0d acc=%0d expected 3 5", carry_cnt, accepted_cnt);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_sum = 32'hA0 + 32'(i);
         cyc(1);
      end
      checks++;
      if (count !== CW'(3)) begin
         errors++; $display("FAIL flush_pre: got count=%0d expected 3", count);
      end
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_sum = 32'h99;
      cyc(1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (count !== '0 || out_valid !== 1'b0 || in_allow !== 1'b1 || accepted_cnt !== 16'd3) begin
         errors++;
         $display("FAIL flush_post: got count=%0d valid=%b allow=%b acc=%0d expected 0 0 1 3",
                  count, out_valid, in_allow, accepted_cnt);
      end
      in_valid = 1'b1; in_sum = 32'h55;
      cyc(1);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         if (i == 7) out_ready = 1'b0;
         in_valid = 1'b1; in_sum = 32'(100 + i);
         cyc(1);
      end
      checks++;
      if (count !== CW'(2) || accepted_cnt !== 16'd7) begin
         errors++; $display("FAIL reset_mid_pre: got count=%0d acc=%0d expected 2 7", count, accepted_cnt);
      end
      rst = 1'b1; in_valid = 1'b1; in_carry = 1'b1;
      cyc(1);
      rst = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
      checks++;
      if (count !== '0 || accepted_cnt !== 16'd0 || carry_cnt !== 16'd0 ||
          out_valid !== 1'b0 || in_allow !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_post: got count=%0d acc=%0d car=%0d valid=%b allow=%b expected 0 0 0 0 1",
                  count, accepted_cnt, carry_cnt, out_valid, in_allow);
      end
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_full();
      test_streaming_wrap();
      test_carry_stats();
      test_flush();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_result_buffer.md
# adder_result_buffer

Show-ahead result FIFO that sits directly downstream of the 4-stage stallable pipelined adder. It captures each `{carry, sum}` result the adder presents on its valid output and drives the adder's `out_allow` back-pressure input. It then hands results to a consumer over a valid/ready handshake and keeps simple result statistics. Flushing the buffer is aligned with the adder's stage-refresh mechanism.

## Interface
Parameters:
- `WIDTH`, default 32: sum width; must match the adder.
- `DEPTH`, default 4: entry count; power of two, at least 2.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `flush`, in, 1: synchronous discard of all buffered entries.
- `in_valid`, in, 1: adder result valid (adder `vaild_out`).
- `in_sum`, in, `WIDTH`: adder `sum_out`.
- `in_carry`, in, 1: adder `c_out`.
- `in_allow`, out, 1: buffer can accept a result; drives adder `out_allow`.
- `out_valid`, out, 1: head entry is available.
- `out_ready`, in, 1: consumer takes the head entry this cycle.
- `out_sum`, out, `WIDTH`: head entry sum.
- `out_carry`, out, 1: head entry carry.
- `count`, out, `$clog2(DEPTH)+1`: number of occupied entries.
- `accepted_cnt`, out, 16: total results accepted; wraps modulo 2^16.
- `carry_cnt`, out, 16: accepted results with carry = 1; saturates at 0xFFFF.

## Operation
Storage and pointers:
- Circular storage of `DEPTH` entries, each `WIDTH+1` bits.
- Write pointer and read pointer, each `$clog2(DEPTH)` bits, wrap naturally.
- `count` register, 0..`DEPTH`.

Handshake signals:
- `in_allow` = (`count` != `DEPTH`). It is purely a function of registered state. It has no combinational path from `out_ready`, so no pass-through occurs when full.
- Push occurs when `in_valid && in_allow && !flush`. The entry is written at the write pointer, and the write pointer increments.
- `out_valid` = (`count` != 0).
- `out_sum` / `out_carry` = entry at the read pointer (show-ahead, combinational read of the head). Their value is don't-care when `out_valid` = 0.
- Pop occurs when `out_valid && out_ready && !flush`; the read pointer increments.

Count update:
- Push only: `count` +1.
- Pop only: `count` −1.
- Push and pop together: `count` unchanged.

Statistics:
- On each push, `accepted_cnt` +1 (wrapping).
- On each push with `in_carry` = 1, `carry_cnt` +1, holding at 0xFFFF.
- Pops do not affect statistics.

Flush:
- Pointers and `count` go to 0, and any push or pop in the same cycle is suppressed.
- A result presented during flush is dropped and not counted. It is still considered taken by the adder, because the adder's refresh also invalidates it.
- Statistics are retained.

Reset:
- Pointers, `count`, `accepted_cnt`, and `carry_cnt` go to 0.
- `rst` has priority over `flush`.
- Storage contents are not cleared.

Reset values of outputs:
- `in_allow` = 1, `out_valid` = 0, `count` = 0, `accepted_cnt` = 0, `carry_cnt` = 0.
- `out_sum` / `out_carry` are undefined.

## Timing
- Latency: a result accepted at edge N appears on `out_*` with `out_valid` = 1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 result per cycle in steady state while 0 < `count` < `DEPTH` and the consumer is ready.
- Full (`count` = `DEPTH`):
  - `in_allow` = 0 for that whole cycle, even if `out_ready` = 1.
  - The adder's held `vaild_out`/`sum_out` must not be captured.
  - After a pop at edge N, `in_allow` = 1 in cycle N+1.
- Empty (`count` = 0): `out_valid` = 0, so `out_ready` is ignored and no underflow can occur.
- Push and pop in the same cycle with `count` = 1: the head advances to the new entry and `count` stays 1.
- Pointer wrap: entry order is preserved across the `DEPTH−1` → 0 transition.
- Adder stall tolerance:
  - The adder holds `vaild_out` high with a stable sum while `out_allow` = 0.
  - The buffer must capture that result exactly once, on the first cycle `in_allow` = 1.
- Reset mid-stream: buffered entries are lost, and the cycle after `rst` deasserts looks exactly like post-reset.

## Test plan
- Reset then single push:
  - Stimulus: hold `out_ready` = 0, present `in_sum` = 0x0000_0003, `in_carry` = 0 for one cycle.
  - Required: next cycle `out_valid` = 1, `out_sum` = 0x0000_0003, `count` = 1, `accepted_cnt` = 1.
- Fill to full, DEPTH = 4:
  - Stimulus: push 0x10, 0x11, 0x12, 0x13 with `out_ready` = 0, then hold `in_valid` = 1 with 0x14.
  - Required: `in_allow` = 0 and `count` = 4. Set `out_ready` = 1; pops return 0x10..0x13 in order, then 0x14 is accepted exactly once, and `accepted_cnt` = 5.
- Streaming across wrap:
  - Stimulus: 12 consecutive pushes 1..12 with `out_ready` = 1 throughout.
  - Required: `count` never exceeds 1 and outputs appear as 1..12 one cycle delayed.
- Carry statistics:
  - Stimulus: 3 pushes with `in_carry` = 1 (e.g. sum 0xFFFF_FFFF + 1), 2 pushes with `in_carry` = 0.
  - Required: `carry_cnt` = 3, `accepted_cnt` = 5, and `out_carry` follows per entry.
- Flush with simultaneous push and pop:
  - Stimulus: `count` = 3, then assert `flush` with `in_valid` = 1 and `out_ready` = 1.
  - Required: next cycle `count` = 0, `out_valid` = 0, `in_allow` = 1, and `accepted_cnt` unchanged.
- Reset mid-operation:
  - Stimulus: `count` = 2, `accepted_cnt` = 7, then assert `rst` for one cycle with `in_valid` = 1.
  - Required: afterwards `count` = 0, `accepted_cnt` = 0, `carry_cnt` = 0, and `out_valid` = 0.
